// File: rtl/uart_pkg.sv
// Shared definitions for the UART link (receiver and transmitter).
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: the serial line in, and the parallel byte bus out.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] dout;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport master (input rx, output dout, output valid, output frame_err, output busy);
  modport slave  (output rx, input dout, input valid, input frame_err, input busy);

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; resets to the idle level.
module uart_sync2
  import uart_pkg::*;
#(
  parameter logic RESET_VAL = LINE_IDLE
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a configurable clocks-per-bit divider.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.master bus
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  uart_state_t          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] dout_q, dout_n;
  logic                 valid_q, valid_n;
  logic                 ferr_q, ferr_n;
  logic                 rx_s;

  uart_sync2 #(.RESET_VAL(LINE_IDLE)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, counters, shift register and strobes; all decisions use rx_s.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    dout_n  = dout_q;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_s == 1'b0) begin
          cnt_n = '0;
          idx_n = '0;
          if (HALF == 0) state_n = DATA;
          else           state_n = START;
        end
      end
      START: begin
        cnt_n = cnt + ONE;
        if ((cnt + ONE) == HALF_C) begin
          if (rx_s == 1'b0) begin
            state_n = DATA;
            cnt_n   = '0;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == LAST_C) begin
          cnt_n               = '0;
          shreg_n[idx[2:0]]   = rx_s;
          idx_n               = idx + 4'd1;
          if (idx == LAST_BIT) state_n = STOP;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      STOP: begin
        if (cnt == LAST_C) begin
          cnt_n = '0;
          if (rx_s == LINE_IDLE) begin
            dout_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s == LINE_IDLE) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath registers; reset discards any partially received byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      dout_q  <= dout_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != IDLE);

endmodule
